cla32_mp_sequencer: RTL

- Multi-precision add/subtract sequencer for the ThresholdCutter datapath.
- Owns one 32-bit carry-lookahead adder instance with ports a, b, ci, s, co.
- Processes a WORDS*32-bit operand pair one 32-bit word per cycle, LSW first, chaining the carry through a register.
- Start/busy/done handshake; result, carry-out and signed overflow are held registered until the next accepted start.

---
 rtl/cla32_mp_sequencer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/cla32_mp_sequencer.sv
// Multi-precision add/subtract sequencer built around one 32-bit
// carry-lookahead adder. Operands of WORDS*32 bits are processed one
// word per cycle, least significant word first, with the carry chained
// through a register between words.

// 32-bit carry-lookahead adder: 4-bit lookahead groups joined by a
// group-level generate/propagate carry chain.
module cla32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ci,
    output logic [31:0] s,
    output logic        co
);
    logic [31:0] p;
    logic [31:0] g;
    logic [31:0] c;
    logic [7:0]  grp_p;
    logic [7:0]  grp_g;
    logic [8:0]  grp_c;

    assign p = a ^ b;
    assign g = a & b;

    // Group propagate/generate, group carries, then per-bit carries inside each group
    always_comb begin
        grp_p = '0;
        grp_g = '0;
        grp_c = '0;
        c     = '0;
        for (int j = 0; j < 8; j++) begin
            grp_p[j] = p[4*j+3] & p[4*j+2] & p[4*j+1] & p[4*j];
            grp_g[j] = g[4*j+3]
                     | (p[4*j+3] & g[4*j+2])
                     | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                     | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
        end
        grp_c[0] = ci;
        for (int j = 0; j < 8; j++) begin
            grp_c[j+1] = grp_g[j] | (grp_p[j] & grp_c[j]);
        end
        for (int j = 0; j < 8; j++) begin
            c[4*j]   = grp_c[j];
            c[4*j+1] = g[4*j] | (p[4*j] & grp_c[j]);
            c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j])
                     | (p[4*j+1] & p[4*j] & grp_c[j]);
            c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1])
                     | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & grp_c[j]);
        end
    end

    assign s  = p ^ c;
    assign co = grp_c[8];
endmodule

// Sequencer: start/busy/done handshake, operand latches, word index,
// carry register and the registered result.
module cla32_mp_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                sub,
    input  logic                ci_in,
    input  logic [WORDS*32-1:0] a,
    input  logic [WORDS*32-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [WORDS*32-1:0] s,
    output logic                co,
    output logic                ovf
);
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_next;
    logic   accept;

    logic [WORDS-1:0][31:0] a_lat;
    logic [WORDS-1:0][31:0] b_lat;
    logic                   sub_lat;
    logic                   carry_reg;
    logic [IDX_W-1:0]       idx;
    logic [WORDS-1:0][31:0] s_reg;
    logic                   co_reg;
    logic                   ovf_reg;

    logic [31:0] a_word;
    logic [31:0] b_eff_word;
    logic [31:0] sum_word;
    logic        sum_co;
    logic        last_word;

    // Subtraction is a + ~b + 1: invert B here, the +1 comes from carry_reg
    assign a_word     = a_lat[idx];
    assign b_eff_word = sub_lat ? ~b_lat[idx] : b_lat[idx];
    assign last_word  = (idx == LAST_IDX);

    cla32 u_cla32 (
        .a  (a_word),
        .b  (b_eff_word),
        .ci (carry_reg),
        .s  (sum_word),
        .co (sum_co)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake decode; DONE can accept a new start directly
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_word) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture on accept, then one word per RUN edge into the result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_lat     <= '0;
            b_lat     <= '0;
            sub_lat   <= 1'b0;
            carry_reg <= 1'b0;
            idx       <= '0;
            s_reg     <= '0;
            co_reg    <= 1'b0;
            ovf_reg   <= 1'b0;
        end else if (accept) begin
            a_lat     <= a;
            b_lat     <= b;
            sub_lat   <= sub;
            carry_reg <= sub | ci_in;
            idx       <= '0;
        end else if (state == RUN) begin
            s_reg[idx] <= sum_word;
            carry_reg  <= sum_co;
            idx        <= idx + IDX_ONE;
            if (last_word) begin
                co_reg  <= sum_co;
                ovf_reg <= (a_word[31] == b_eff_word[31]) & (sum_word[31] != a_word[31]);
            end
        end
    end

    assign s   = s_reg;
    assign co  = co_reg;
    assign ovf = ovf_reg;
endmodule
